// File: rtl/wb_cmd_pkg.sv
// Shared constants for the byte-stream Wishbone command master:
// opcodes, status codes and the control FSM state encoding.
package wb_cmd_pkg;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam logic [7:0] ST_ACK     = 8'h00;
    localparam logic [7:0] ST_ERR     = 8'h01;
    localparam logic [7:0] ST_RTY     = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;
    localparam logic [7:0] ST_BADOP   = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CYCLE,
        S_STATUS,
        S_RDATA
    } state_e;

endpackage

// File: rtl/wb_cmd_txser.sv
// Response serializer: one status byte, optionally followed by the data word
// LSB first. tx_data_o/tx_valid_o are registered and held until accepted.
module wb_cmd_txser #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [7:0]            status_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  with_data_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  done_o
);

    localparam int D  = DATA_WIDTH / 8;
    localparam int CW = $clog2(D + 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic [7:0]            byte_q, byte_d;
    logic                  valid_q, valid_d;
    logic                  xfer;

    assign xfer       = valid_q & tx_ready_i;
    assign done_o     = xfer && (rem_q == '0);
    assign tx_data_o  = byte_q;
    assign tx_valid_o = valid_q;

    // NOTE: every variable gets its hold value first, so no path through the
    // branches below can leave one unassigned and infer a latch.
    always_comb begin
        shift_d = shift_q;
        rem_d   = rem_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        if (load_i) begin
            valid_d = 1'b1;
            byte_d  = status_i;
            shift_d = data_i;
            rem_d   = with_data_i ? CW'(D) : '0;
        end else if (xfer) begin
            if (rem_q != '0) begin
                byte_d  = shift_q[7:0];
                shift_d = shift_q >> 8;
                rem_d   = rem_q - CW'(1);
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            rem_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Byte-stream to classic Wishbone master bridge. Optional cycle timeout is
// compiled in with `define WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic                    wbm_we_o,
    output logic [SELECT_WIDTH-1:0] wbm_sel_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_cyc_o,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    input  logic                    wbm_rty_i
);

    localparam int A = ADDR_WIDTH / 8;
    localparam int D = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  is_wr_q, is_wr_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic                  ser_load, ser_with_data, ser_done;
    logic [7:0]            ser_status;
    logic                  tmo_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Counts cycles spent in CYCLE; zero everywhere else, so it is clear on entry.
    assign tmo_d   = (state_q == S_CYCLE) ? tmo_q + TW'(1) : '0;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        is_wr_d       = is_wr_q;
        cyc_d         = cyc_q;
        we_d          = we_q;
        ser_load      = 1'b0;
        ser_status    = ST_ACK;
        ser_with_data = 1'b0;
        rx_ready      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    cnt_d = '0;
                    if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                        is_wr_d = (rx_data == OP_WRITE);
                        state_d = S_ADDR;
                    end else begin
                        ser_load   = 1'b1;
                        ser_status = ST_BADOP;
                        state_d    = S_STATUS;
                    end
                end
            end
            S_ADDR: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    adr_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'(A - 1)) begin
                        cnt_d = '0;
                        if (is_wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_CYCLE;
                            cyc_d   = 1'b1;
                            we_d    = 1'b0;
                        end
                    end
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    dat_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'(D - 1)) begin
                        cnt_d   = '0;
                        state_d = S_CYCLE;
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                    end
                end
            end
            S_CYCLE: begin
                // err beats rty beats ack; a real termination beats the timeout.
                if (wbm_err_i || wbm_rty_i || wbm_ack_i) begin
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    ser_load = 1'b1;
                    state_d  = S_STATUS;
                    if (wbm_err_i) begin
                        ser_status = ST_ERR;
                    end else if (wbm_rty_i) begin
                        ser_status = ST_RTY;
                    end else begin
                        ser_status    = ST_ACK;
                        ser_with_data = ~is_wr_q;
                    end
                end else if (tmo_hit) begin
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    ser_load   = 1'b1;
                    ser_status = ST_TIMEOUT;
                    state_d    = S_STATUS;
                end
            end
            S_STATUS: begin
                if (tx_valid && tx_ready) state_d = ser_done ? S_IDLE : S_RDATA;
            end
            S_RDATA: begin
                if (ser_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            is_wr_q <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            is_wr_q <= is_wr_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
        end
    end

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_sel_o = {SELECT_WIDTH{cyc_q}};

    wb_cmd_txser #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_txser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ser_load),
        .status_i   (ser_status),
        .data_i     (wbm_dat_i),
        .with_data_i(ser_with_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .done_o     (ser_done)
    );

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: expected response bytes are queued as
// commands are issued and compared as the DUT emits them.
module tb_wb_cmd_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i = '0;
    logic          wbm_we_o;
    logic [SW-1:0] wbm_sel_o;
    logic          wbm_stb_o;
    logic          wbm_cyc_o;
    logic          wbm_ack_i = 1'b0;
    logic          wbm_err_i = 1'b0;
    logic          wbm_rty_i = 1'b0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       stall_q = 1'b0;
    logic [7:0] stall_data = '0;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .SELECT_WIDTH  (SW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i),
        .wbm_rty_i(wbm_rty_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted byte and checks
    // that a stalled byte is held unchanged.
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("tx_hold_valid", {63'd0, tx_valid}, 64'd1);
                check("tx_hold_data", {56'd0, tx_data}, {56'd0, stall_data});
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("tx_extra_byte", {56'd0, tx_data}, 64'h100);
                else                   check("tx_byte", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
            end
            stall_q    = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!rx_ready) check("rx_accept_timeout", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat);
        send_byte(op);
        if (op == 8'h01 || op == 8'h02)
            for (int i = 0; i < 4; i++) send_byte(adr[i*8 +: 8]);
        if (op == 8'h02)
            for (int i = 0; i < 4; i++) send_byte(dat[i*8 +: 8]);
    endtask

    // Plays a Wishbone slave for one cycle; called right after the last command byte.
    task automatic wb_respond(input string tag, input logic exp_we, input logic [31:0] exp_adr,
                              input logic [31:0] exp_dat, input int delay,
                              input logic a, input logic e, input logic r, input logic [31:0] rdata);
        check({tag, "_stb_latency"}, {63'd0, wbm_stb_o}, 64'd1);
        check({tag, "_cyc"}, {63'd0, wbm_cyc_o}, 64'd1);
        check({tag, "_adr"}, {32'd0, wbm_adr_o}, {32'd0, exp_adr});
        check({tag, "_we"}, {63'd0, wbm_we_o}, {63'd0, exp_we});
        check({tag, "_sel"}, {60'd0, wbm_sel_o}, 64'hF);
        if (exp_we) check({tag, "_dat"}, {32'd0, wbm_dat_o}, {32'd0, exp_dat});
        repeat (delay) begin
            @(posedge clk);
            #1;
            check({tag, "_held"}, {62'd0, wbm_cyc_o, wbm_stb_o}, 64'd3);
        end
        wbm_ack_i = a;
        wbm_err_i = e;
        wbm_rty_i = r;
        wbm_dat_i = rdata;
        @(posedge clk);
        #1;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_rty_i = 1'b0;
        check({tag, "_cyc_drop"}, {61'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 64'd0);
        check({tag, "_status_latency"}, {63'd0, tx_valid}, 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        logic seen;

        #12;
        check("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_data", {56'd0, tx_data}, 64'd0);
        check("rst_wb_ctrl", {61'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 64'd0);
        check("rst_sel", {60'd0, wbm_sel_o}, 64'd0);
        check("rst_adr", {32'd0, wbm_adr_o}, 64'd0);
        check("rst_dat", {32'd0, wbm_dat_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write 0xDEADBEEF to 0x10, ack after 2 cycles.
        exp_q.push_back(8'h00);
        send_cmd(8'h02, 32'h0000_0010, 32'hDEAD_BEEF);
        wb_respond("wr", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_drain("wr");
        check("wr_adr_hold", {32'd0, wbm_adr_o}, 64'h10);
        check("wr_dat_hold", {32'd0, wbm_dat_o}, 64'hDEAD_BEEF);

        // Read 0x04 returning 0x12345678.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        send_cmd(8'h01, 32'h0000_0004, 32'h0);
        wb_respond("rd", 1'b0, 32'h0000_0004, 32'h0, 1, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
        wait_drain("rd");

        // Terminations other than plain ack, and their priority.
        exp_q.push_back(8'h01);
        send_cmd(8'h01, 32'h0000_0020, 32'h0);
        wb_respond("rd_err", 1'b0, 32'h0000_0020, 32'h0, 0, 1'b0, 1'b1, 1'b0, 32'hAAAA_5555);
        wait_drain("rd_err");

        exp_q.push_back(8'h01);
        send_cmd(8'h01, 32'h0000_0024, 32'h0);
        wb_respond("rd_all", 1'b0, 32'h0000_0024, 32'h0, 1, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
        wait_drain("rd_all");

        exp_q.push_back(8'h02);
        send_cmd(8'h01, 32'h8000_0028, 32'h0);
        wb_respond("rd_rty_ack", 1'b0, 32'h8000_0028, 32'h0, 0, 1'b1, 1'b0, 1'b1, 32'h0BAD_0BAD);
        wait_drain("rd_rty_ack");

        // Bad opcode: status only, no bus activity.
        exp_q.push_back(8'h04);
        send_cmd(8'h7F, 32'h0, 32'h0);
        seen = wbm_cyc_o;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen = seen | wbm_cyc_o | wbm_stb_o;
        end
        check("badop_no_wb", {63'd0, seen}, 64'd0);
        wait_drain("badop");

        // Stray terminations while idle are ignored.
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        @(posedge clk);
        #1;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stray_ack_tx", {63'd0, tx_valid}, 64'd0);
        check("stray_ack_rx_ready", {63'd0, rx_ready}, 64'd1);

        // Read with backpressure on the response stream.
        tx_ready = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'h89);
        send_cmd(8'h01, 32'h0000_0100, 32'h0);
        wb_respond("bp", 1'b0, 32'h0000_0100, 32'h0, 0, 1'b1, 1'b0, 1'b0, 32'h89AB_CDEF);
        repeat (5) @(posedge clk);
        #1;
        check("bp_rx_blocked", {63'd0, rx_ready}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            tx_ready = i[0];
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        wait_drain("bp");

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        // Unresponsive slave: cycle aborted after TMO cycles with status 0x03.
        exp_q.push_back(8'h03);
        send_cmd(8'h01, 32'h0000_0200, 32'h0);
        hi = 0;
        while (wbm_cyc_o && hi < 100) begin
            hi++;
            @(posedge clk);
            #1;
        end
        check("tmo_cyc_cycles", 64'(hi), 64'(TMO));
        check("tmo_status_latency", {63'd0, tx_valid}, 64'd1);
        wait_drain("tmo");
        send_cmd(8'h01, 32'h0000_0300, 32'h0);
        repeat (3) @(posedge clk);
        #1;
`else
        // Unresponsive slave: the cycle is held indefinitely.
        send_cmd(8'h01, 32'h0000_0300, 32'h0);
        hi = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            hi += int'(wbm_cyc_o);
        end
        check("no_tmo_cyc_held", 64'(hi), 64'd40);
`endif

        // Asynchronous reset in the middle of a bus cycle.
        check("pre_rst_cyc", {63'd0, wbm_cyc_o}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_cyc_stb", {62'd0, wbm_cyc_o, wbm_stb_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_release_rx_ready", {63'd0, rx_ready}, 64'd1);
        check("rst_release_tx_valid", {63'd0, tx_valid}, 64'd0);

        exp_q.push_back(8'h00);
        send_cmd(8'h02, 32'h0000_0040, 32'h0102_0304);
        wb_respond("post_rst_wr", 1'b1, 32'h0000_0040, 32'h0102_0304, 0, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_drain("post_rst_wr");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Byte-stream to Wishbone master bridge.
- Sits directly upstream of the Wishbone slave multiplexer.
- Takes command bytes from the host link (USB FIFO / UART receive path) and runs single classic Wishbone read/write cycles on the mux master port.
- Returns a status byte, plus read data when applicable, on an outgoing byte stream.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width in bits; must be a multiple of 8, max 32.
- DATA_WIDTH, 32, Wishbone data width in bits; must be 8, 16 or 32.
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT_CYCLES, 1023, cycles to wait for ack/err/rty before aborting; used only with the timeout feature.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  command byte
- rx_valid  in  1  command byte valid
- rx_ready  out  1  block accepts rx_data this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  response byte valid
- tx_ready  in  1  downstream accepts tx_data
- wbm_adr_o  out  ADDR_WIDTH  Wishbone address
- wbm_dat_o  out  DATA_WIDTH  Wishbone write data
- wbm_dat_i  in  DATA_WIDTH  Wishbone read data
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  SELECT_WIDTH  byte select
- wbm_stb_o  out  1  strobe
- wbm_cyc_o  out  1  cycle
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  error
- wbm_rty_i  in  1  retry

Behaviour:
- Clock and reset: single clock domain (clk); rst asynchronous, active-high.
- Reset values: all outputs 0 except rx_ready=1. FSM goes to IDLE.
- Byte handshakes: a byte transfers on a cycle with valid&ready. tx_data/tx_valid are registered and held stable until tx_ready.
- Command format: opcode byte, then A=ADDR_WIDTH/8 address bytes (little-endian), then for writes D=DATA_WIDTH/8 data bytes (little-endian).
  - 0x01 = read
  - 0x02 = write
  - Any other opcode: no address/data bytes.
- Response format: one status byte, then for a successful read D data bytes (little-endian).
  - Status codes: 0x00 ack, 0x01 err, 0x02 rty, 0x03 timeout, 0x04 bad opcode.
  - Data bytes are sent only when a read completes with ack.
- FSM states:
  - IDLE: rx_ready=1. Opcode 0x01/0x02 -> ADDR with byte counter=0. Other opcode -> status 0x04, go to STATUS.
  - ADDR: shift in A bytes. After the last byte, go to DATA (write) or CYCLE (read).
  - DATA: shift in D bytes. After the last byte, go to CYCLE.
  - CYCLE: rx_ready=0; cyc=stb=1, we as decoded, sel all-ones. These signals are asserted the cycle after entry and stay held while waiting.
    - The first of ack/err/rty seen ends the cycle. Priority on simultaneous assertion: err > rty > ack.
    - On that edge, cyc/stb/we drop to 0 and read data is latched on ack. Go to STATUS.
  - STATUS: tx_valid=1 with the status byte. On tx_ready, go to RDATA (read+ack) or IDLE.
  - RDATA: emit D bytes, LSB first. After the last accepted byte, go to IDLE.
- rx_ready=0 in CYCLE, STATUS and RDATA. Commands are never pipelined.
- Latency: the Wishbone strobe asserts 1 cycle after the last command byte. The status byte becomes valid 1 cycle after the terminating ack/err/rty.
- wbm_adr_o/wbm_dat_o hold their last values between cycles.
- Reset mid-cycle drops cyc/stb immediately (asynchronous) and discards any partial command.
- An ack arriving while not in CYCLE is ignored.

Optional Feature:
- Macro: WB_CMD_MASTER_TIMEOUT_EN.
- Defined: a counter clears on CYCLE entry and increments each CYCLE cycle. When it reaches TIMEOUT_CYCLES with no ack/err/rty, the block drops cyc/stb and emits status 0x03. A termination arriving on the same cycle as the timeout wins over the timeout.
- Undefined: no counter exists; CYCLE waits indefinitely and status 0x03 is never produced.

Decomposition:
- Shared package wb_cmd_pkg holds:
  - opcode constants: OP_READ=0x01, OP_WRITE=0x02
  - status constants: ST_ACK, ST_ERR, ST_RTY, ST_TIMEOUT, ST_BADOP
  - the FSM state encoding
- One natural sub-module, wb_cmd_txser: a byte serializer for the status byte plus data word, with its own valid/ready handshake and byte counter.

Test Plan:
- Write: rx 02, 10 00 00 00, EF BE AD DE; slave acks after 2 cycles -> adr=0x00000010, dat=0xDEADBEEF, we=1, sel=0xF; tx 00.
- Read: rx 01, 04 00 00 00; slave returns 0x12345678 with ack -> we=0; tx 00 78 56 34 12.
- Err and rty: read with err=1 -> tx 01 only, no data bytes. Then err+rty+ack asserted together -> tx 01.
- Bad opcode and backpressure: rx 7F -> tx 04, no Wishbone activity. Then a read with tx_ready held low 5 cycles -> tx_data stable, no byte lost or duplicated.
- Timeout (macro defined, TIMEOUT_CYCLES=16): slave never responds -> cyc drops after 16 cycles; tx 03. Macro undefined -> cyc stays high.
- Reset: assert rst mid-CYCLE -> cyc/stb=0 immediately and rx_ready=1 after release; a following write completes normally.
